// File: rtl/sad_pkg.sv
// Shared widths and types for the SAD minimum-select path.
package sad_pkg;

  localparam int SAD_W = 32;
  localparam int PIX_W = 8;

  typedef logic [SAD_W-1:0] sad_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } sel_state_t;

endpackage

// File: rtl/sad_min_cmp.sv
// Combinational running-minimum update: a candidate replaces the current best when it
// is taken unconditionally (first_i) or is strictly smaller, so ties keep the earlier index.
module sad_min_cmp
  import sad_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [SAD_W-1:0] cur_min_i,
  input  logic [IDX_W-1:0] cur_idx_i,
  input  logic [SAD_W-1:0] sad_i,
  input  logic [IDX_W-1:0] cnt_i,
  input  logic             first_i,
  output logic [SAD_W-1:0] nxt_min_o,
  output logic [IDX_W-1:0] nxt_idx_o
);

  logic take;

  assign take      = first_i || (sad_i < cur_min_i);
  assign nxt_min_o = take ? sad_i : cur_min_i;
  assign nxt_idx_o = take ? cnt_i : cur_idx_i;

endmodule

// File: rtl/sad_min_select.sv
// Tracks the minimum SAD over N_CAND candidates and publishes it with a done pulse.
// Optional SAD_EARLY_EXIT_EN adds thresh_i/early_o to end a search on a good-enough match.
module sad_min_select
  import sad_pkg::*;
#(
  parameter int N_CAND = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      sad_valid_i,
  input  logic [31:0]               sad_i,
`ifdef SAD_EARLY_EXIT_EN
  input  logic [31:0]               thresh_i,
  output logic                      early_o,
`endif
  output logic                      sad_ready_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [31:0]               best_sad_o,
  output logic [$clog2(N_CAND)-1:0] best_idx_o
);

  localparam int IDX_W = $clog2(N_CAND);
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N_CAND - 1);

  sel_state_t       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  sad_t             min_q, min_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  sad_t             best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             early_q, early_d;

  logic             accept;
  logic             hit;
  sad_t             nxt_min;
  logic [IDX_W-1:0] nxt_idx;

  assign accept = sad_valid_i && (state_q == COLLECT);

`ifdef SAD_EARLY_EXIT_EN
  assign hit     = accept && (sad_i <= thresh_i);
  assign early_o = early_q;
`else
  assign hit = 1'b0;
`endif

  // A threshold hit is forced in as the best, same as the first candidate.
  sad_min_cmp #(.IDX_W(IDX_W)) u_cmp (
    .cur_min_i (min_q),
    .cur_idx_i (idx_q),
    .sad_i     (sad_i),
    .cnt_i     (cnt_q),
    .first_i   ((cnt_q == '0) || hit),
    .nxt_min_o (nxt_min),
    .nxt_idx_o (nxt_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    min_d      = min_q;
    idx_d      = idx_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    early_d    = early_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = COLLECT;
          cnt_d   = '0;
          min_d   = '1;
          idx_d   = '0;
        end
      end
      COLLECT: begin
        if (accept) begin
          min_d = nxt_min;
          idx_d = nxt_idx;
          cnt_d = cnt_q + 1'b1;
          // Results are loaded on the way into DONE so they are valid with done_o.
          if ((cnt_q == LAST_CNT) || hit) begin
            state_d    = DONE;
            best_sad_d = nxt_min;
            best_idx_d = nxt_idx;
            early_d    = hit;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      min_q      <= '0;
      idx_q      <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
      early_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      min_q      <= min_d;
      idx_q      <= idx_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      early_q    <= early_d;
    end
  end

  assign sad_ready_o = (state_q == COLLECT);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign best_sad_o  = best_sad_q;
  assign best_idx_o  = best_idx_q;

endmodule

// File: tb/tb_sad_min_select.sv
// Directed + randomized check of sad_min_select (N_CAND=4) against a list-based model.
module tb_sad_min_select;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, start, vld;
  logic [31:0] sad, thresh;
  logic        early;
  logic        ready, busy, done;
  logic [31:0] best_sad;
  logic [1:0]  best_idx;

  int tests = 0;
  int fails = 0;

  logic [31:0] last_best;
  logic [31:0] last_idx;
  logic        last_early;

  always #5 clk = ~clk;

  sad_min_select #(.N_CAND(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .sad_valid_i (vld),
    .sad_i       (sad),
`ifdef SAD_EARLY_EXIT_EN
    .thresh_i    (thresh),
    .early_o     (early),
`endif
    .sad_ready_o (ready),
    .busy_o      (busy),
    .done_o      (done),
    .best_sad_o  (best_sad),
    .best_idx_o  (best_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan the candidate list in arrival order.
  task automatic model(input logic [31:0] vals[$], output int nacc, output logic [31:0] eb,
                       output logic [31:0] ei, output logic ee);
    nacc = N; eb = 0; ei = 0; ee = 1'b0;
    for (int i = 0; i < N; i++) begin
`ifdef SAD_EARLY_EXIT_EN
      if (vals[i] <= thresh) begin
        eb = vals[i]; ei = i; ee = 1'b1; nacc = i + 1;
        break;
      end
`endif
      if (i == 0 || vals[i] < eb) begin
        eb = vals[i]; ei = i;
      end
    end
  endtask

  task automatic run_search(input string tag, input logic [31:0] vals[$], input int gaps[$],
                            input int gap_max, input bit poke_start);
    int nacc, g;
    logic [31:0] eb, ei;
    logic ee;
    model(vals, nacc, eb, ei, ee);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1);
    chk({tag, " ready_collect"}, ready, 1);
    chk({tag, " best_held"}, best_sad, last_best);
    for (int i = 0; i < nacc; i++) begin
      g = (i < gaps.size()) ? gaps[i] : $urandom_range(0, gap_max);
      for (int k = 0; k < g; k++) begin
        vld = 1'b0;
        sad = $urandom;
        start = poke_start;
        step();
        start = 1'b0;
        chk({tag, " ready_gap"}, ready, 1);
      end
      vld = 1'b1;
      sad = vals[i];
      step();
      vld = 1'b0;
      if (i < nacc - 1) chk({tag, " no_early_done"}, done, 0);
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " ready_in_done"}, ready, 0);
    chk({tag, " best_sad"}, best_sad, eb);
    chk({tag, " best_idx"}, best_idx, ei);
`ifdef SAD_EARLY_EXIT_EN
    chk({tag, " early"}, early, ee);
`endif
    step();
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " busy_idle"}, busy, 0);
    chk({tag, " best_hold"}, best_sad, eb);
    last_best = eb; last_idx = ei; last_early = ee;
  endtask

  initial begin
    logic [31:0] v[$];
    int          gz[$];
    rst = 1'b1; start = 1'b0; vld = 1'b0; sad = '0; thresh = '0;
    last_best = '0; last_idx = '0; last_early = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst ready", ready, 0);
    chk("rst done", done, 0);
    chk("rst best_sad", best_sad, 0);
    chk("rst best_idx", best_idx, 0);
    // valid while idle is ignored
    vld = 1'b1; sad = 32'd1; step(); vld = 1'b0;
    chk("idle vld ignored", busy, 0);

    gz = {};
    v = '{32'd500, 32'd120, 32'd300, 32'd121};
    run_search("basic", v, gz, 0, 1'b0);
    v = '{32'd90, 32'd40, 32'd40, 32'd70};
    run_search("tie", v, gz, 0, 1'b0);
    v = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_search("allmax", v, gz, 0, 1'b0);
    gz = '{0, 2, 0, 1};
    v = '{32'd7, 32'd3, 32'd9, 32'd1};
    run_search("gaps", v, gz, 0, 1'b1);

    // abort after two accepts
    start = 1'b1; step(); start = 1'b0;
    vld = 1'b1; sad = 32'd1; step();
    sad = 32'd2; step(); vld = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort ready", ready, 0);
    chk("abort best_sad", best_sad, 0);
    chk("abort best_idx", best_idx, 0);
    last_best = '0;
    gz = {};
    v = '{32'd10, 32'd20, 32'd5, 32'd8};
    run_search("post_abort", v, gz, 0, 1'b0);

`ifdef SAD_EARLY_EXIT_EN
    thresh = 32'd50;
    v = '{32'd200, 32'd45, 32'd10, 32'd5};
    run_search("early", v, gz, 0, 1'b0);
    v = '{32'd200, 32'd300, 32'd400, 32'd30};
    run_search("early_last", v, gz, 0, 1'b0);
    thresh = '0;
`endif

    for (int r = 0; r < 24; r++) begin
      v = {};
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 2))
          0:       v.push_back($urandom_range(1, 6));
          1:       v.push_back(32'hFFFF_FFFF - $urandom_range(0, 2));
          default: v.push_back($urandom);
        endcase
      end
`ifdef SAD_EARLY_EXIT_EN
      thresh = ($urandom_range(0, 1) != 0) ? 32'd3 : 32'd0;
`endif
      run_search("rand", v, gz, 3, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
